imem_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 21 ++
 rtl/imem_loader.sv | 147 ++++++++++++++
 tb/tb_imem_loader.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the instruction-memory boot loader.
package imem_loader_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    CNT_HI  = 3'd0,
    CNT_LO  = 3'd1,
    DATA_HI = 3'd2,
    DATA_LO = 3'd3,
    CHK     = 3'd4,
    RUN     = 3'd5,
    ERR     = 3'd6
  } state_e;

  function automatic logic [BYTE_W-1:0] chk_fold(input logic [BYTE_W-1:0] acc,
                                                  input logic [BYTE_W-1:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Boot loader: receives a framed byte stream, writes 16-bit words into
// instruction memory from address 0, verifies an XOR checksum, releases the CPU.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int I_ADDR_W = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [BYTE_W-1:0]   rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  input  logic                load_req,
  output logic                cpu_reset,
  output logic                mem_write,
  output logic [I_ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]    mem_wdata,
  output logic                done,
  output logic                error,
  output logic [2:0]          state_out
);

  localparam int unsigned MAX_N = 2 ** I_ADDR_W;

  state_e                state_q;
  logic [15:0]           cnt_q;
  logic [I_ADDR_W:0]     idx_q;
  logic [BYTE_W-1:0]     acc_q;
  logic [BYTE_W-1:0]     hi_q;
  logic                  rx_ready_q;
  logic                  cpu_reset_q;
  logic                  mem_write_q;
  logic [I_ADDR_W-1:0]   mem_addr_q;
  logic [WIDTH-1:0]      mem_wdata_q;
  logic                  done_q;
  logic                  error_q;

  logic                  xfer;
  logic [15:0]           cnt_d;
  logic [BYTE_W-1:0]     acc_d;
  logic                  last_word;

  assign xfer      = rx_valid & rx_ready_q;
  assign cnt_d     = {cnt_q[15:8], rx_data};
  assign acc_d     = chk_fold(acc_q, rx_data);
  assign last_word = (16'(idx_q) + 16'd1) == cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= CNT_HI;
      cnt_q       <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      hi_q        <= '0;
      rx_ready_q  <= 1'b1;
      cpu_reset_q <= 1'b1;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      mem_write_q <= 1'b0;
      // Index advances as the write cycle retires, so the next word sees it.
      if (mem_write_q) idx_q <= idx_q + 1'b1;

      case (state_q)
        CNT_HI: if (xfer) begin
          cnt_q   <= {rx_data, 8'h00};
          acc_q   <= acc_d;
          state_q <= CNT_LO;
        end
        CNT_LO: if (xfer) begin
          cnt_q <= cnt_d;
          acc_q <= acc_d;
          if (cnt_d == 16'd0 || 32'(cnt_d) > MAX_N) begin
            state_q    <= ERR;
            error_q    <= 1'b1;
            rx_ready_q <= 1'b0;
          end else begin
            idx_q   <= '0;
            state_q <= DATA_HI;
          end
        end
        DATA_HI: if (xfer) begin
          hi_q    <= rx_data;
          acc_q   <= acc_d;
          state_q <= DATA_LO;
        end
        DATA_LO: if (xfer) begin
          acc_q       <= acc_d;
          mem_write_q <= 1'b1;
          mem_addr_q  <= idx_q[I_ADDR_W-1:0];
          mem_wdata_q <= WIDTH'({hi_q, rx_data});
          state_q     <= last_word ? CHK : DATA_HI;
        end
        CHK: if (xfer) begin
          rx_ready_q <= 1'b0;
          if (rx_data == acc_q) begin
            state_q     <= RUN;
            cpu_reset_q <= 1'b0;
            done_q      <= 1'b1;
          end else begin
            state_q <= ERR;
            error_q <= 1'b1;
          end
        end
        RUN: if (load_req) begin
          state_q     <= CNT_HI;
          cpu_reset_q <= 1'b1;
          done_q      <= 1'b0;
          rx_ready_q  <= 1'b1;
          acc_q       <= '0;
          cnt_q       <= '0;
          idx_q       <= '0;
        end
        ERR: begin
          cpu_reset_q <= 1'b1;
          if (load_req) begin
            state_q    <= CNT_HI;
            error_q    <= 1'b0;
            rx_ready_q <= 1'b1;
            acc_q      <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
          end
        end
        default: begin
          state_q    <= ERR;
          error_q    <= 1'b1;
          rx_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx_ready  = rx_ready_q;
  assign cpu_reset = cpu_reset_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign error     = error_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued as bytes are sent.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        load_req;
  logic        cpu_reset;
  logic        mem_write;
  logic [6:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        done;
  logic        error;
  logic [2:0]  state_out;

  int errs   = 0;
  int checks = 0;
  logic [22:0] exp_q[$];
  logic [15:0] wq[$];
  int          last_addr = -1;

  always #5 clk = ~clk;

  imem_loader dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .load_req(load_req), .cpu_reset(cpu_reset),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .done(done), .error(error), .state_out(state_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mem_write === 1'b1) begin
      if (exp_q.size() == 0) chk("wr_spurious", 32'(mem_addr), 32'hFFFF_FFFF);
      else begin
        logic [22:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e[22:16]));
        chk("wr_data", 32'(mem_wdata), 32'(e[15:0]));
        last_addr = int'(mem_addr);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit gaps);
    if (gaps) begin
      int k;
      k = $urandom_range(0, 3);
      rx_valid = 1'b0;
      for (int i = 0; i < k; i++) begin
        rx_data = 8'($urandom);
        tick();
      end
    end
    if (rx_ready !== 1'b1) chk("rx_ready", 32'(rx_ready), 1);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  // Sends count, the words in wq and a checksum (corrupted when bad=1).
  task automatic send_frame(input bit bad, input bit gaps);
    logic [7:0]  x;
    logic [15:0] n;
    n = 16'(wq.size());
    x = n[15:8] ^ n[7:0];
    send(n[15:8], gaps);
    send(n[7:0], gaps);
    for (int i = 0; i < wq.size(); i++) begin
      x = x ^ wq[i][15:8] ^ wq[i][7:0];
      send(wq[i][15:8], gaps);
      exp_q.push_back({7'(i), wq[i]});
      send(wq[i][7:0], gaps);
    end
    send(bad ? (x ^ 8'h01) : x, gaps);
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic check_run(input string tag);
    chk({tag, "_state"}, 32'(state_out), 5);
    chk({tag, "_cpurst"}, 32'(cpu_reset), 0);
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_rdy"}, 32'(rx_ready), 0);
    tick();
    chk({tag, "_sb"}, 32'(exp_q.size()), 0);
  endtask

  task automatic check_err(input string tag);
    chk({tag, "_state"}, 32'(state_out), 6);
    chk({tag, "_err"}, 32'(error), 1);
    chk({tag, "_cpurst"}, 32'(cpu_reset), 1);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; load_req = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_state", 32'(state_out), 0);
    chk("rst_cpurst", 32'(cpu_reset), 1);
    chk("rst_rdy", 32'(rx_ready), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(error), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wdata", 32'(mem_wdata), 0);

    // 1: two-word frame, back-to-back
    wq = '{16'h3000, 16'h4000};
    send_frame(1'b0, 1'b0);
    check_run("t1");

    // 2: bad checksum, then recover
    pulse_load();
    chk("t2_reload_cpurst", 32'(cpu_reset), 1);
    send_frame(1'b1, 1'b0);
    check_err("t2");
    tick();
    chk("t2_hold_state", 32'(state_out), 6);
    pulse_load();
    chk("t2_clr_state", 32'(state_out), 0);
    chk("t2_clr_err", 32'(error), 0);
    send_frame(1'b0, 1'b0);
    check_run("t2b");

    // 3: illegal counts, then full-capacity frame
    pulse_load();
    send(8'h00, 1'b0); send(8'h00, 1'b0);
    check_err("t3_zero");
    pulse_load();
    send(8'h00, 1'b0); send(8'h81, 1'b0);
    check_err("t3_over");
    pulse_load();
    wq = {};
    for (int i = 0; i < 128; i++) wq.push_back(16'($urandom));
    send_frame(1'b0, 1'b0);
    check_run("t3_full");
    chk("t3_last_addr", 32'(last_addr), 127);

    // 4: same as test 1 with random rx_valid gaps; load_req ignored mid-frame
    pulse_load();
    wq = '{16'h3000, 16'h4000};
    fork
      send_frame(1'b0, 1'b1);
      begin
        tick(); tick(); tick();
        load_req = 1'b1; tick(); load_req = 1'b0;
      end
    join
    check_run("t4");

    // 5: reset mid-frame
    pulse_load();
    send(8'h00, 1'b0); send(8'h02, 1'b0); send(8'h30, 1'b0);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t5_state", 32'(state_out), 0);
    chk("t5_cpurst", 32'(cpu_reset), 1);
    chk("t5_wr", 32'(mem_write), 0);
    send_frame(1'b0, 1'b0);
    check_run("t5");

    // 6: reload from RUN with a one-word frame
    pulse_load();
    chk("t6_cpurst", 32'(cpu_reset), 1);
    chk("t6_state", 32'(state_out), 0);
    chk("t6_done", 32'(done), 0);
    wq = '{16'h1234};
    send_frame(1'b0, 1'b0);
    check_run("t6");

    // reset and load_req together: reset wins
    load_req = 1'b1; reset = 1'b1; tick();
    load_req = 1'b0; reset = 1'b0;
    chk("rst_win_state", 32'(state_out), 0);
    chk("rst_win_done", 32'(done), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
